// File: rtl/store_align_buf_pkg.sv
// Shared types and constants for the store alignment buffer.
//   be_byte/be_half/be_word : store width codes driven by the MEM stage
//   sb_beop_rsvd            : reserved width code, always raises AdES
//   sb_entry_t              : one buffered, already-aligned store
package store_align_buf_pkg;

  localparam int unsigned addr_w = 32;
  localparam int unsigned data_w = 32;
  localparam int unsigned be_w   = 4;

  typedef enum logic [1:0] {
    be_byte      = 2'b00,
    be_half      = 2'b01,
    be_word      = 2'b10,
    sb_beop_rsvd = 2'b11
  } beop_e;

  typedef struct packed {
    logic [addr_w-3:0] waddr;
    logic [data_w-1:0] wdata;
    logic [be_w-1:0]   be;
  } sb_entry_t;

endpackage

// File: rtl/store_align_buf_if.sv
// Store/load request and data-memory drain bus of the store alignment buffer.
//   st_*  : MEM-stage store request (valid/ready) and AdES flag
//   ld_*  : MEM-stage load probe and stall indication
//   mem_* : head-of-buffer drain toward the data memory (valid/ready)
// master = pipeline/memory side, slave = the buffer.
interface store_align_buf_if;
  import store_align_buf_pkg::*;

  logic              st_valid;
  logic              st_ready;
  logic [addr_w-1:0] st_addr;
  logic [data_w-1:0] st_data;
  logic [1:0]        st_beop;
  logic              st_exc;
  logic              ld_valid;
  logic [addr_w-1:0] ld_addr;
  logic              ld_conflict;
  logic              mem_valid;
  logic              mem_ready;
  logic [addr_w-1:0] mem_addr;
  logic [data_w-1:0] mem_wdata;
  logic [be_w-1:0]   mem_be;

  modport master (
    output st_valid, st_addr, st_data, st_beop, ld_valid, ld_addr, mem_ready,
    input  st_ready, st_exc, ld_conflict, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_beop, ld_valid, ld_addr, mem_ready,
    output st_ready, st_exc, ld_conflict, mem_valid, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/store_be_gen.sv
// Combinational store aligner: byte-enable generation, lane replication and
// misalignment / reserved-width detection.
//   addr_lo : store address bits [1:0]
//   beop    : width code
//   data    : rt value, data in the low bits
//   be      : byte enables, bit k = lane k
//   wdata   : data replicated across the lanes
//   bad     : misaligned or reserved width (AdES cause)
module store_be_gen
  import store_align_buf_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  beop_e             beop,
  input  logic [data_w-1:0] data,
  output logic [be_w-1:0]   be,
  output logic [data_w-1:0] wdata,
  output logic              bad
);

  always_comb begin
    be    = '0;
    wdata = '0;
    bad   = 1'b0;
    case (beop)
      be_byte: begin
        be    = be_w'(4'b0001 << addr_lo);
        wdata = {4{data[7:0]}};
      end
      be_half: begin
        bad   = addr_lo[0];
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      be_word: begin
        bad   = (addr_lo != 2'b00);
        be    = 4'b1111;
        wdata = data;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_align_buf.sv
// Store alignment buffer: aligns MEM-stage stores, flags AdES, queues them in a
// DEPTH-entry FIFO and drains the head to the data memory.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : store_align_buf_if.slave (store request, load probe, DM drain)
//   empty      : no buffered stores
//   count      : occupancy, 0..DEPTH
// Optional: define SB_LOAD_CHECK_EN to stall loads only on a word-address hit
// against a buffered store; otherwise any load stalls until the buffer is empty.
module store_align_buf
  import store_align_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  store_align_buf_if.slave             bus,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned ptr_w = $clog2(DEPTH);
  localparam int unsigned cnt_w = $clog2(DEPTH+1);

  sb_entry_t         ent_q [DEPTH];
  sb_entry_t         head;
  logic [ptr_w-1:0]  wr_ptr;
  logic [ptr_w-1:0]  rd_ptr;
  logic [cnt_w-1:0]  cnt_q;
  logic [be_w-1:0]   be_c;
  logic [data_w-1:0] wdata_c;
  logic              bad_c;
  logic              full;
  logic              push;
  logic              pop;

  store_be_gen u_be_gen (
    .addr_lo (bus.st_addr[1:0]),
    .beop    (beop_e'(bus.st_beop)),
    .data    (bus.st_data),
    .be      (be_c),
    .wdata   (wdata_c),
    .bad     (bad_c)
  );

  // Status comes straight from the occupancy register, so reset clears it at once.
  assign full  = (cnt_q == cnt_w'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // No full-bypass: a pop in the same cycle does not open a slot for the store.
  assign bus.st_ready = !full;
  assign bus.st_exc   = bus.st_valid & bad_c;
  assign push         = bus.st_valid & !full & !bad_c;
  assign pop          = bus.mem_valid & bus.mem_ready;

  // Drain side reads the registered head entry; it holds while stalled.
  assign head          = ent_q[rd_ptr];
  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = {head.waddr, 2'b00};
  assign bus.mem_wdata = head.wdata;
  assign bus.mem_be    = head.be;

  // FIFO storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        ent_q[wr_ptr] <= '{waddr: bus.st_addr[addr_w-1:2], wdata: wdata_c, be: be_c};
        wr_ptr        <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + cnt_w'(1);
        2'b01:   cnt_q <= cnt_q - cnt_w'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef SB_LOAD_CHECK_EN
  logic             hit;
  logic [ptr_w-1:0] idx;
  logic             unused_ld_lo;

  // Compare the load word address against occupied entries only (offsets below count).
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + ptr_w'(k);
      if ((cnt_w'(k) < cnt_q) && (ent_q[idx].waddr == bus.ld_addr[addr_w-1:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign bus.ld_conflict = bus.ld_valid & hit;
  assign unused_ld_lo    = ^bus.ld_addr[1:0];
`else
  logic unused_ld_addr;

  // Without address compare, any buffered store blocks the load.
  assign bus.ld_conflict = bus.ld_valid & !empty;
  assign unused_ld_addr  = ^bus.ld_addr;
`endif

endmodule

// File: tb/tb_store_align_buf.sv
// Directed bench for store_align_buf with a queue scoreboard of expected drains.
module tb_store_align_buf;
  import store_align_buf_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       empty;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  store_align_buf_if bus ();

  store_align_buf #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .empty (empty),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference alignment written lane by lane.
  function automatic void model_align(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] op, output logic bad,
                                      output logic [3:0] be, output logic [31:0] wd);
    bad = 1'b0;
    be  = 4'b0000;
    wd  = 32'h0;
    if (op == be_byte) begin
      be[a[1:0]] = 1'b1;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[7:0];
    end else if (op == be_half) begin
      bad = a[0];
      if (!bad) begin
        be[a[1:0]]        = 1'b1;
        be[a[1:0] + 2'd1] = 1'b1;
      end
      for (int i = 0; i < 2; i++) wd[16*i +: 16] = d[15:0];
    end else if (op == be_word) begin
      bad = (a[1:0] != 2'b00);
      be  = 4'b1111;
      wd  = d;
    end else begin
      bad = 1'b1;
    end
  endfunction

  // One clock cycle: drive at negedge, check combinational/head outputs, then state after posedge.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [1:0] op, input logic mr, input logic lv,
                      input logic [31:0] la);
    logic        m_bad;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic        exp_exc;
    logic        exp_rdy;
    logic        exp_conf;
    logic        do_push;
    logic        do_pop;
    exp_t        e;
    bus.st_valid  = sv;
    bus.st_addr   = sa;
    bus.st_data   = sd;
    bus.st_beop   = op;
    bus.mem_ready = mr;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    #1;
    model_align(sa, sd, op, m_bad, m_be, m_wd);
    exp_exc = sv & m_bad;
    exp_rdy = (sb_q.size() < DEPTH);
    exp_conf = 1'b0;
    if (lv) begin
`ifdef SB_LOAD_CHECK_EN
      foreach (sb_q[i]) if (sb_q[i].addr[31:2] == la[31:2]) exp_conf = 1'b1;
`else
      exp_conf = (sb_q.size() != 0);
`endif
    end
    chk("st_ready", 32'(bus.st_ready), 32'(exp_rdy));
    chk("st_exc", 32'(bus.st_exc), 32'(exp_exc));
    chk("ld_conflict", 32'(bus.ld_conflict), 32'(exp_conf));
    chk("mem_valid", 32'(bus.mem_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      chk("mem_addr", bus.mem_addr, sb_q[0].addr);
      chk("mem_wdata", bus.mem_wdata, sb_q[0].wd);
      chk("mem_be", 32'(bus.mem_be), 32'(sb_q[0].be));
    end
    do_push = sv & exp_rdy & !exp_exc;
    do_pop  = (sb_q.size() != 0) && mr;
    if (do_pop) void'(sb_q.pop_front());
    if (do_push) begin
      e.addr = {sa[31:2], 2'b00};
      e.wd   = m_wd;
      e.be   = m_be;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk("count", 32'(count), 32'(sb_q.size()));
    chk("empty", 32'(empty), 32'(sb_q.size() == 0));
  endtask

  task automatic idle(input logic mr);
    step(1'b0, 32'h0, 32'h0, be_byte, mr, 1'b0, 32'h0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    reset         = 1'b1;
    bus.st_valid  = 1'b0;
    bus.st_addr   = 32'h0;
    bus.st_data   = 32'h0;
    bus.st_beop   = 2'b00;
    bus.mem_ready = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
    @(negedge clk);

    // Byte store at lane 3, visible one cycle later
    step(1'b1, 32'h13, 32'h000000A5, be_byte, 1'b0, 1'b0, 32'h0);
    chk("t1_mem_be", 32'(bus.mem_be), 32'h8);
    chk("t1_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    chk("t1_mem_addr", bus.mem_addr, 32'h10);
    idle(1'b1);

    // Halfword stores, misaligned and reserved width
    step(1'b1, 32'h22, 32'h0000BEEF, be_half, 1'b0, 1'b0, 32'h0);
    chk("t2_mem_be", 32'(bus.mem_be), 32'hC);
    chk("t2_mem_wdata", bus.mem_wdata, 32'hBEEFBEEF);
    step(1'b1, 32'h21, 32'h00001234, be_half, 1'b0, 1'b0, 32'h0);
    chk("t2_exc_count", 32'(count), 32'd1);
    step(1'b1, 32'h30, 32'h11111111, sb_beop_rsvd, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h42, 32'h22222222, be_word, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h21, 32'h0, be_half, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h50, 32'h0000CAFE, be_half, 1'b1, 1'b0, 32'h0);
    idle(1'b1);

    // Fill to DEPTH with a stalled drain; fifth store held until a slot frees
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h100 + 32'(4 * i), 32'h11111111 * 32'(i + 1), be_word, 1'b0, 1'b0, 32'h0);
    chk("t3_full_count", 32'(count), 32'd4);
    step(1'b1, 32'h200, 32'hDEADBEEF, be_word, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h200, 32'hDEADBEEF, be_word, 1'b1, 1'b0, 32'h0);
    chk("t3_after_pop_count", 32'(count), 32'd3);
    step(1'b1, 32'h200, 32'hDEADBEEF, be_word, 1'b0, 1'b0, 32'h0);
    repeat (4) idle(1'b1);

    // Steady push+pop at occupancy 2, mixed widths
    step(1'b1, 32'h300, 32'hA1A2A3A4, be_word, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h304, 32'hB1B2B3B4, be_word, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 3);
      a  = 32'h400 + 32'(16 * i);
      if (op == be_byte) a[1:0] = 2'(i);
      else if (op == be_half) a[1] = 1'(i);
      step(1'b1, a, $urandom, op, 1'b1, 1'b0, 32'h0);
      chk("t4_count_hold", 32'(count), 32'd2);
    end
    repeat (2) idle(1'b1);

    // Load probes against a buffered word store
    step(1'b1, 32'h40, 32'h0BADF00D, be_word, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, be_byte, 1'b0, 1'b1, 32'h42);
    step(1'b0, 32'h0, 32'h0, be_byte, 1'b0, 1'b1, 32'h44);
    step(1'b0, 32'h0, 32'h0, be_byte, 1'b0, 1'b0, 32'h40);
    step(1'b0, 32'h0, 32'h0, be_byte, 1'b1, 1'b1, 32'h40);
    step(1'b0, 32'h0, 32'h0, be_byte, 1'b1, 1'b1, 32'h40);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h500 + 32'(4 * i), 32'h5A5A0000 + 32'(i), be_word, 1'b0, 1'b0, 32'h0);
    bus.st_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_mem_addr", bus.mem_addr, 32'h0);
    chk("t6_mem_wdata", bus.mem_wdata, 32'h0);
    chk("t6_mem_be", 32'(bus.mem_be), 32'h0);
    chk("t6_st_ready", 32'(bus.st_ready), 32'd1);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) idle(1'b1);
    step(1'b1, 32'h62, 32'h000000C3, be_byte, 1'b0, 1'b0, 32'h0);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
